// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared state encoding and constants for the memory-copy DMA
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } dma_state_e;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] BLE_ALL    = 4'b1111;

endpackage

// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - word-by-word memory copy engine over a wait-state memory port
// Optional strobe timeout/abort enabled by defining DMA_TIMEOUT_EN.
module mem_copy_dma
    import dma_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] src_i,
    input  logic [31:0] dst_i,
    input  logic [15:0] len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] mem_add_o,
    output logic        mem_re_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_ble_o,
    output logic [31:0] mem_d_o,
    input  logic [31:0] mem_d_i,
    input  logic        mem_valid_i
);

    dma_state_e  state_q, state_d;
    logic [31:0] src_q, dst_q, data_q;
    logic [15:0] cnt_q;
    logic        tmo_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
    end

`ifdef DMA_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] tmo_q;
    logic          err_q;

    // Fires on the last allowed strobe cycle so the strobe is high for exactly TIMEOUT_CYCLES cycles.
    assign tmo_hit = (state_q == RD || state_q == WR) && !mem_valid_i
                     && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            if ((state_q == RD || state_q == WR) && state_d == state_q)
                tmo_q <= tmo_q + 1'b1;
            else
                tmo_q <= '0;
            if (state_q == IDLE)
                err_q <= 1'b0;
            else if (tmo_hit)
                err_q <= 1'b1;
        end
    end

    assign err_o = (state_q == DONE) && err_q;
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start_i) begin
                    src_q <= {src_i[31:2], 2'b00};
                    dst_q <= {dst_i[31:2], 2'b00};
                    cnt_q <= len_i;
                end
                RD: if (mem_valid_i) data_q <= mem_d_i;
                WR: if (mem_valid_i) begin
                    cnt_q <= cnt_q - 16'd1;
                    src_q <= src_q + 32'(WORD_BYTES);
                    dst_q <= dst_q + 32'(WORD_BYTES);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        mem_add_o = '0;
        mem_re_o  = 1'b0;
        mem_we_o  = 1'b0;
        mem_ble_o = '0;
        mem_d_o   = '0;
        case (state_q)
            IDLE: if (start_i) state_d = (len_i != 16'd0) ? RD : DONE;
            RD: begin
                busy_o    = 1'b1;
                mem_re_o  = 1'b1;
                mem_add_o = src_q;
                if (mem_valid_i)  state_d = WR;
                else if (tmo_hit) state_d = DONE;
            end
            WR: begin
                busy_o    = 1'b1;
                mem_we_o  = 1'b1;
                mem_ble_o = BLE_ALL;
                mem_d_o   = data_q;
                mem_add_o = dst_q;
                if (mem_valid_i)  state_d = (cnt_q == 16'd1) ? DONE : GAP;
                else if (tmo_hit) state_d = DONE;
            end
            GAP: begin
                busy_o  = 1'b1;
                state_d = RD;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb/tb_mem_copy_dma.sv - scoreboard bench for mem_copy_dma with a wait-state memory responder
module tb_mem_copy_dma;

    localparam int TMO = 8;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] src = '0, dst = '0;
    logic [15:0] len = '0;
    logic        busy_o, done_o, err_o, mem_re_o, mem_we_o;
    logic [31:0] mem_add_o, mem_d_o;
    logic [3:0]  mem_ble_o;
    logic [31:0] mem_d_i = '0;
    logic        mem_valid_i = 1'b0;

    mem_copy_dma #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .src_i(src), .dst_i(dst), .len_i(len),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .mem_add_o(mem_add_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_ble_o(mem_ble_o),
        .mem_d_o(mem_d_o), .mem_d_i(mem_d_i), .mem_valid_i(mem_valid_i)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input int idx);
        return 32'hC0DE_0000 ^ (32'(idx) * 32'h9E37_79B1);
    endfunction

    // Wait-state memory: valid pulses one cycle after ws extra strobe cycles.
    logic [31:0] mem [0:1023];
    int  ws = 0, wcnt = 0;
    bit  never = 1'b0, preload = 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            mem_valid_i <= 1'b0;
            wcnt        <= 0;
            if (preload) for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
        end else if (mem_valid_i) begin
            mem_valid_i <= 1'b0;
            wcnt        <= 0;
        end else if ((mem_re_o || mem_we_o) && !never) begin
            if (wcnt >= ws) begin
                mem_valid_i <= 1'b1;
                if (mem_we_o) mem[mem_add_o[11:2]] <= mem_d_o;
                else          mem_d_i <= mem[mem_add_o[11:2]];
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    typedef struct {
        logic [31:0] add;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];
    int  gaps[$];

    int  rd_cnt, wr_cnt, done_cnt, busy_seen, strobe_seen, stab_err, ble_err;
    int  last_rd_cyc, last_wr_cyc, last_done_cyc, gap_run;
    bit  last_err, gap_open, prev_act, prev_re, prev_we;
    logic [31:0] prev_add, prev_d;

    always @(negedge clk) begin
        if (rst) begin
            prev_act = 1'b0;
            gap_open = 1'b0;
        end else begin
            if (prev_act && (mem_re_o !== prev_re || mem_we_o !== prev_we ||
                             mem_add_o !== prev_add || mem_d_o !== prev_d)) stab_err++;
            prev_act = (mem_re_o || mem_we_o) && !mem_valid_i;
            prev_re  = mem_re_o;
            prev_we  = mem_we_o;
            prev_add = mem_add_o;
            prev_d   = mem_d_o;
            if (!mem_we_o && mem_ble_o !== 4'b0000) ble_err++;
            if (busy_o) busy_seen++;
            if (mem_re_o || mem_we_o) strobe_seen++;
            if (gap_open) begin
                if (mem_re_o) begin
                    gaps.push_back(gap_run);
                    gap_open = 1'b0;
                end else if (done_o) begin
                    gap_open = 1'b0;
                end else if (!mem_we_o) begin
                    gap_run++;
                end
            end
            if (done_o) begin
                done_cnt++;
                last_done_cyc = cyc;
                last_err      = err_o;
            end
            if (mem_re_o && mem_valid_i) begin
                rd_cnt++;
                last_rd_cyc = cyc;
            end
            if (mem_we_o && mem_valid_i) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                gap_open    = 1'b1;
                gap_run     = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_write: got add=%h data=%h, required no write", mem_add_o, mem_d_o);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (mem_add_o !== e.add || mem_d_o !== e.data || mem_ble_o !== 4'b1111) begin
                        errors++;
                        $display("FAIL sb_write: got add=%h data=%h ble=%b, required add=%h data=%h ble=1111",
                                 mem_add_o, mem_d_o, mem_ble_o, e.add, e.data);
                    end
                end
            end
        end
    end

    task automatic clear_stats();
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_seen = 0; strobe_seen = 0;
        stab_err = 0; ble_err = 0; last_err = 1'b0;
        gaps.delete();
    endtask

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l, input bit expect_wr);
        @(negedge clk);
        src = s; dst = d; len = l; start = 1'b1;
        if (expect_wr)
            for (int i = 0; i < int'(l); i++)
                exp_q.push_back('{add: {d[31:2], 2'b00} + 32'(i * 4), data: pat(int'(s[11:2]) + i)});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_o !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: got no done_o within %0d cycles, required done_o=1", budget);
        end
        @(negedge clk);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({busy_o, done_o, err_o, mem_re_o, mem_we_o} !== 5'b0 || mem_ble_o !== 4'b0 ||
            mem_d_o !== 32'b0 || mem_add_o !== 32'b0) begin
            errors++;
            $display("FAIL %s: got busy=%b done=%b err=%b re=%b we=%b ble=%b d=%h add=%h, required all 0",
                     name, busy_o, done_o, err_o, mem_re_o, mem_we_o, mem_ble_o, mem_d_o, mem_add_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_outputs");
        rst = 1'b0;
        preload = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_single();
        ws = 5;
        clear_stats();
        start_copy(32'h0001_0000, 32'h0001_0100, 16'd1, 1'b1);
        wait_done(200);
        check_int("single_reads", rd_cnt, 1);
        check_int("single_writes", wr_cnt, 1);
        check_int("single_read_before_write", int'(last_rd_cyc < last_wr_cyc), 1);
        check_int("single_done_latency", last_done_cyc - last_wr_cyc, 1);
        check_int("single_err", int'(last_err), 0);
        check_int("single_done_pulse", int'(done_o), 0);
        check_int("single_dst_word", int'(mem[64] === pat(0)), 1);
        check_int("single_strobe_stable", stab_err, 0);
        check_int("single_ble_zero", ble_err, 0);
        check_int("single_sb_empty", exp_q.size(), 0);
    endtask

    task automatic test_multi();
        ws = 2;
        clear_stats();
        start_copy(32'h0001_0020, 32'h0001_0200, 16'd3, 1'b1);
        wait_done(300);
        check_int("multi_writes", wr_cnt, 3);
        check_int("multi_gap_count", gaps.size(), 2);
        foreach (gaps[i]) check_int($sformatf("multi_gap_len_%0d", i), gaps[i], 1);
        for (int i = 0; i < 3; i++)
            check_int($sformatf("multi_dst_word_%0d", i), int'(mem[128 + i] === pat(8 + i)), 1);
        check_int("multi_strobe_stable", stab_err, 0);
        check_int("multi_done_count", done_cnt, 1);
    endtask

    task automatic test_zero_len();
        clear_stats();
        start_copy(32'h0001_0400, 32'h0001_0500, 16'd0, 1'b0);
        check_int("zero_done_next_cycle", int'(done_o), 1);
        @(negedge clk);
        check_int("zero_done_pulse", int'(done_o), 0);
        repeat (5) @(negedge clk);
        check_int("zero_busy_never", busy_seen, 0);
        check_int("zero_no_strobes", strobe_seen, 0);
        check_int("zero_done_count", done_cnt, 1);
    endtask

    task automatic test_ignore_start();
        ws = 3;
        clear_stats();
        start_copy(32'h0001_0040, 32'h0001_0300, 16'd3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            repeat (4) @(negedge clk);
            src = 32'h0001_0060; dst = 32'h0001_0380; len = 16'd2; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(300);
        repeat (10) @(negedge clk);
        check_int("ignore_writes", wr_cnt, 3);
        check_int("ignore_sb_empty", exp_q.size(), 0);
        check_int("ignore_done_count", done_cnt, 1);
        check_int("ignore_busy_after", int'(busy_o), 0);
        check_int("ignore_other_dst_untouched", int'(mem[224] === pat(224)), 1);
        check_int("ignore_dst_word_2", int'(mem[194] === pat(18)), 1);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        ws = 10;
        clear_stats();
        start_copy(32'h0001_0060, 32'h0001_0280, 16'd2, 1'b0);
        while (mem_we_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_int("rstmid_reached_wr", int'(mem_we_o), 1);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("rstmid_outputs_zero");
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (10) @(negedge clk);
        check_int("rstmid_no_done", done_cnt, 0);
        check_int("rstmid_idle", int'(busy_o), 0);
        check_int("rstmid_dst_untouched", int'(mem[160] === pat(160)), 1);
        exp_q.delete();
        clear_stats();
        ws = 1;
        start_copy(32'h0001_0070, 32'h0001_0320, 16'd1, 1'b1);
        wait_done(100);
        check_int("rstmid_restart_writes", wr_cnt, 1);
        check_int("rstmid_restart_sb_empty", exp_q.size(), 0);
        check_int("rstmid_restart_dst", int'(mem[200] === pat(28)), 1);
    endtask

`ifdef DMA_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        never = 1'b1;
        clear_stats();
        start_copy(32'h0001_0000, 32'h0001_0600, 16'd1, 1'b0);
        while (mem_re_o === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_int("timeout_strobe_cycles", n, TMO);
        check_int("timeout_done", int'(done_o), 1);
        check_int("timeout_err", int'(err_o), 1);
        @(negedge clk);
        check_int("timeout_done_pulse", int'(done_o | err_o), 0);
        never = 1'b0;
        check_int("timeout_no_writes", wr_cnt, 0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_zero_len();
        test_ignore_start();
        test_reset_mid();
`ifdef DMA_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the max cycles a memory strobe waits for mem_valid_i (used only when DMA_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port start_i, input, 1, one-cycle copy request.
REQ-005 SHALL have port src_i, input, 32, source byte address; bits [1:0] ignored.
REQ-006 SHALL have port dst_i, input, 32, destination byte address; bits [1:0] ignored.
REQ-007 SHALL have port len_i, input, 16, number of 32-bit words to copy.
REQ-008 SHALL have port busy_o, output, 1, high while a copy is in progress.
REQ-009 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port err_o, output, 1, high with done_o when the copy was aborted.
REQ-011 SHALL have ports mem_add_o (output, 32), mem_re_o, mem_we_o (output, 1), mem_ble_o (output, 4), mem_d_o (output, 32), mem_d_i (input, 32) and mem_valid_i (input, 1), the initiator side of the wait-state memory handshake.

Function
REQ-012 SHALL implement states IDLE, RD, WR, GAP, DONE.
REQ-013 SHALL leave IDLE on start_i=1 and latch src_i, dst_i and len_i: to RD if len_i!=0, else directly to DONE with no memory access.
REQ-014 SHALL ignore start_i in every state except IDLE.
REQ-015 SHALL in RD drive mem_re_o=1, mem_add_o={src[31:2],2'b00}, mem_we_o=0, and hold all of them stable until mem_valid_i=1.
REQ-016 SHALL on mem_valid_i=1 in RD capture mem_d_i into a data register and go to WR.
REQ-017 SHALL in WR drive mem_we_o=1, mem_ble_o=4'b1111, mem_d_o=the data register, mem_add_o={dst[31:2],2'b00}, and hold them until mem_valid_i=1.
REQ-018 SHALL on mem_valid_i=1 in WR decrement the word count and add 4 to src and dst, with addresses wrapping modulo 2^32; it then goes to DONE if the count becomes 0, else to GAP.
REQ-019 SHALL in GAP hold mem_re_o and mem_we_o low for exactly one cycle, then go to RD.
REQ-020 SHALL ignore mem_valid_i outside RD and WR.
REQ-021 SHALL drive done_o=1 for exactly one cycle in DONE, then go to IDLE.
REQ-022 SHALL assert busy_o in RD, WR and GAP only.
REQ-023 SHALL drive mem_re_o, mem_we_o, mem_ble_o and mem_d_o to 0 in IDLE and DONE; mem_ble_o SHALL be 0 whenever mem_we_o=0.

Reset
REQ-024 SHALL, when rst_i=1 at a clock edge, enter IDLE and set busy_o, done_o, err_o, mem_re_o, mem_we_o, mem_ble_o, mem_d_o, mem_add_o and all internal registers to 0, including mid-transaction, with no done pulse.

Configuration
REQ-025 SHALL, with macro DMA_TIMEOUT_EN defined, count the cycles spent in RD or WR; if mem_valid_i has not been seen after TIMEOUT_CYCLES cycles, it drops the strobes and goes to DONE with err_o=1 alongside done_o.
REQ-026 SHALL, without DMA_TIMEOUT_EN, wait indefinitely in RD or WR, tie err_o to 0 and contain no timeout counter.

Structure
REQ-027 SHALL take its state enum, WORD_BYTES=4 and BLE_ALL=4'b1111 from shared package dma_pkg.
REQ-028 SHALL be a single FSM module with no sub-module; the testbench reuses the existing wait-state synchronous memory as the responder.

Verification
REQ-029 SHALL test: src=0x10000, dst=0x10100, len=1, responder WS=5 -> one read then one write of the same word, done_o one cycle after the write's valid.
REQ-030 SHALL test: len=3 with memory words A, B, C -> dst words A, B, C, with exactly one strobe-low GAP cycle between each write and the next read.
REQ-031 SHALL test: len=0 -> done_o one cycle after start, busy_o never high, no mem_re_o or mem_we_o.
REQ-032 SHALL test: start_i pulsed again mid-copy with different arguments -> ignored, and the original copy completes unchanged.
REQ-033 SHALL test: rst_i asserted during WR wait -> all outputs 0 on the next cycle, no done_o, and a new start then works normally.
REQ-034 SHALL test: with DMA_TIMEOUT_EN defined, TIMEOUT_CYCLES=8 and a responder that never asserts valid -> strobe drops after 8 cycles and done_o=err_o=1 for one cycle.
